// File: rtl/light_sequencer_pkg.sv
// Shared sizes, state encoding and index helpers
// for the traffic-light phase sequencer.
package light_sequencer_pkg;

  localparam int STATES    = 6;
  localparam int ROADS     = 4;
  localparam int LIGHTS    = 5;
  localparam int COUNT_MAX = 15;

  localparam int CW = $clog2(COUNT_MAX);
  localparam int RW = $clog2(ROADS);
  localparam int LW = $clog2(STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_COUNT,
    S_ALL_RED
  } seq_state_e;

  function automatic logic [RW-1:0] next_road(
    input logic [RW-1:0] r
  );
    return (r == RW'(ROADS - 1)) ? '0 : r + 1'b1;
  endfunction

  function automatic logic last_light(
    input logic [LW-1:0] p
  );
    return p == LW'(LIGHTS - 1);
  endfunction

endpackage

// File: rtl/light_sequencer_phase_timer.sv
// Loadable phase down-counter; done is registered and high while count==1.
// Ports: clk, reset_n, load, dec, value in; done out.
module phase_timer
  import light_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] value,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      // a zero duration still times one cycle
      count <= (value == '0) ? CW'(1) : value;
      done  <= (value <= CW'(1));
    end else if (dec) begin
      count <= count - 1'b1;
      done  <= (count == CW'(2));
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Round-robin road/phase sequencer with memory fetch and all-red override.
// Ports: clk, reset_n, enable, emergency, timing_data in; strobes/indices out.
module light_sequencer
  import light_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          emergency,
  input  logic [CW-1:0] timing_data,
  output logic          timing_enable,
  output logic [RW-1:0] road_address,
  output logic [LW-1:0] light_address,
  output logic          phase_valid,
  output logic          all_red,
  output logic          cycle_done
);

  seq_state_e    state;
  logic [RW-1:0] road;
  logic [LW-1:0] phase;
  logic          t_load;
  logic          t_dec;
  logic          t_done;

  assign t_load = (state == S_LOAD) && !emergency;
  assign t_dec  = (state == S_COUNT) && !emergency;

  phase_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (t_load),
    .dec     (t_dec),
    .value   (timing_data),
    .done    (t_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      road          <= '0;
      phase         <= '0;
      timing_enable <= 1'b0;
      phase_valid   <= 1'b0;
      all_red       <= 1'b0;
      cycle_done    <= 1'b0;
    end else begin
      timing_enable <= 1'b0;
      phase_valid   <= 1'b0;
      all_red       <= 1'b0;
      cycle_done    <= 1'b0;
      if (emergency) begin
        state   <= S_ALL_RED;
        all_red <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (enable) begin
              state         <= S_FETCH;
              timing_enable <= 1'b1;
            end
          end
          S_FETCH: begin
            state <= S_LOAD;
          end
          S_LOAD: begin
            state       <= S_COUNT;
            phase_valid <= 1'b1;
          end
          S_COUNT: begin
            if (t_done) begin
              if (last_light(phase)) begin
                phase      <= '0;
                road       <= next_road(road);
                cycle_done <= (road == RW'(ROADS - 1));
              end else begin
                phase <= phase + 1'b1;
              end
              state         <= enable ? S_FETCH : S_IDLE;
              timing_enable <= enable;
            end else begin
              phase_valid <= 1'b1;
            end
          end
          S_ALL_RED: begin
            // interrupted phase is dropped; resume at next road
            phase         <= '0;
            road          <= next_road(road);
            state         <= enable ? S_FETCH : S_IDLE;
            timing_enable <= enable;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign road_address  = road;
  assign light_address = phase;

endmodule

// File: tb/tb_light_sequencer.sv
// Randomized and directed bench for light_sequencer against
// a position/time-in-phase reference model.
module tb_light_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       emergency = 1'b0;
  logic [3:0] timing_data = '0;
  logic       timing_enable;
  logic [1:0] road_address;
  logic [2:0] light_address;
  logic       phase_valid;
  logic       all_red;
  logic       cycle_done;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [3:0] dur [4][5];

  light_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .emergency     (emergency),
    .timing_data   (timing_data),
    .timing_enable (timing_enable),
    .road_address  (road_address),
    .light_address (light_address),
    .phase_valid   (phase_valid),
    .all_red       (all_red),
    .cycle_done    (cycle_done)
  );

  always #5 clk = ~clk;

  // timing memory: registered read
  always @(posedge clk) begin
    if (timing_enable) begin
      if (light_address < 3'd5)
        timing_data <= dur[road_address][light_address];
      else
        timing_data <= 4'd0;
    end
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // model: position plus cycle offset within the phase
  int m_road, m_phase, m_t;
  bit m_run, m_red, m_cd;

  function automatic int plen(input int r, input int p);
    int d;
    d = int'(dur[r][p]);
    return 2 + ((d == 0) ? 1 : d);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_road = 0; m_phase = 0; m_t = 0;
      m_run = 0; m_red = 0; m_cd = 0;
    end else begin
      m_cd = 0;
      if (emergency) begin
        m_red = 1; m_run = 0; m_t = 0;
      end else if (m_red) begin
        m_red = 0; m_phase = 0;
        m_road = (m_road + 1) % 4;
        m_run = enable; m_t = 0;
      end else if (m_run) begin
        if (m_t == plen(m_road, m_phase) - 1) begin
          m_phase++;
          if (m_phase == 5) begin
            m_phase = 0;
            m_road++;
            if (m_road == 4) begin
              m_road = 0;
              m_cd = 1;
            end
          end
          m_run = enable; m_t = 0;
        end else begin
          m_t++;
        end
      end else if (enable) begin
        m_run = 1; m_t = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("timing_enable", timing_enable, m_run && m_t == 0);
      chk("phase_valid", phase_valid, m_run && m_t >= 2);
      chk("all_red", all_red, m_red);
      chk("cycle_done", cycle_done, m_cd);
      chk("road_address", road_address, m_road);
      chk("light_address", light_address, m_phase);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    emergency = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic set_rot_table();
    for (int r = 0; r < 4; r++) begin
      dur[r][0] = 4'd2;
      dur[r][1] = (r % 2 == 0) ? 4'd13 : 4'd5;
      dur[r][2] = 4'd2;
      dur[r][3] = 4'd1;
      dur[r][4] = 4'd1;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_te"}, timing_enable, 0);
    chk({nm, "_pv"}, phase_valid, 0);
    chk({nm, "_ar"}, all_red, 0);
    chk({nm, "_cd"}, cycle_done, 0);
    chk({nm, "_road"}, road_address, 0);
    chk({nm, "_light"}, light_address, 0);
  endtask

  int n;
  int cyc;
  int pulses[$];
  int roads[$];

  initial begin
    set_rot_table();
    step();
    cmp_en = 1'b1;

    // reset state
    do_reset();
    chk_zero("rst");
    step();
    chk_zero("idle");

    // single 13-cycle phase
    do_reset();
    enable = 1'b1;
    n = 0;
    while (!(timing_enable && light_address == 3'd1) && n < 100) begin
      step(); n++;
    end
    chk("t2_fetch_seen", n < 100, 1);
    chk("t2_road", road_address, 0);
    step();
    chk("t2_load_te", timing_enable, 0);
    chk("t2_load_pv", phase_valid, 0);
    step();
    n = 0;
    while (phase_valid && n < 40) begin
      step(); n++;
    end
    chk("t2_len", n, 13);
    chk("t2_next_light", light_address, 2);
    chk("t2_next_te", timing_enable, 1);

    // full rotation timing
    do_reset();
    enable = 1'b1;
    cyc = 0;
    pulses.delete();
    roads.delete();
    repeat (210) begin
      step(); cyc++;
      if (cycle_done) pulses.push_back(cyc);
      if (timing_enable && light_address == 3'd0)
        roads.push_back(int'(road_address));
    end
    chk("t3_pulses", pulses.size(), 2);
    if (pulses.size() >= 2) begin
      chk("t3_first", pulses[0], 101);
      chk("t3_gap", pulses[1] - pulses[0], 100);
    end
    chk("t3_roads_n", roads.size() >= 5, 1);
    if (roads.size() >= 5) begin
      chk("t3_r0", roads[0], 0);
      chk("t3_r1", roads[1], 1);
      chk("t3_r2", roads[2], 2);
      chk("t3_r3", roads[3], 3);
      chk("t3_r4", roads[4], 0);
    end

    // emergency during road1/phase1
    do_reset();
    enable = 1'b1;
    n = 0;
    while (!(phase_valid && road_address == 2'd1 &&
             light_address == 3'd1) && n < 200) begin
      step(); n++;
    end
    chk("t4_seen", n < 200, 1);
    emergency = 1'b1;
    n = 0;
    repeat (3) begin
      step();
      if (all_red) n++;
    end
    emergency = 1'b0;
    step();
    chk("t4_red_len", n, 3);
    chk("t4_ar_off", all_red, 0);
    chk("t4_te", timing_enable, 1);
    chk("t4_road", road_address, 2);
    chk("t4_light", light_address, 0);

    // enable drop mid-count
    do_reset();
    enable = 1'b1;
    n = 0;
    while (!phase_valid && n < 20) begin
      step(); n++;
    end
    chk("t5_seen", n < 20, 1);
    enable = 1'b0;
    step();
    chk("t5_still_pv", phase_valid, 1);
    step();
    chk("t5_idle_pv", phase_valid, 0);
    chk("t5_idle_te", timing_enable, 0);
    chk("t5_light", light_address, 1);
    step();
    chk("t5_hold_te", timing_enable, 0);
    enable = 1'b1;
    step();
    chk("t5_te", timing_enable, 1);
    chk("t5_road", road_address, 0);
    chk("t5_light2", light_address, 1);

    // zero durations, emergency on last count cycle
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 5; p++) dur[r][p] = 4'd0;
    do_reset();
    enable = 1'b1;
    step();
    chk("t6_fetch", timing_enable, 1);
    step();
    step();
    chk("t6_pv", phase_valid, 1);
    step();
    chk("t6_pv_1cyc", phase_valid, 0);
    chk("t6_next", light_address, 1);
    step();
    step();
    chk("t6_pv2", phase_valid, 1);
    emergency = 1'b1;
    step();
    chk("t6_ar", all_red, 1);
    chk("t6_no_adv", light_address, 1);
    emergency = 1'b0;
    step();
    chk("t6_rel_te", timing_enable, 1);
    chk("t6_rel_road", road_address, 1);
    chk("t6_rel_light", light_address, 0);

    // reset mid-count
    set_rot_table();
    do_reset();
    enable = 1'b1;
    n = 0;
    while (!(phase_valid && light_address == 3'd1) && n < 50) begin
      step(); n++;
    end
    chk("t7_seen", n < 50, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("t7_async");
    enable = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk_zero("t7_idle");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        for (int r = 0; r < 4; r++)
          for (int p = 0; p < 5; p++)
            dur[r][p] = 4'($urandom_range(0, 15));
        step();
        reset_n = 1'b1;
      end
      enable = ($urandom_range(0, 7) != 0);
      emergency = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
